// File: rtl/laser500_pkg.sv
// -----------------------------------------------------------------------------
// laser500_pkg
// Shared types and constants for the Laser 500 SDRAM arbitration path.
//   owner_t     : which requester owns the SDRAM transaction in flight
//   arb_state_t : arbiter FSM states
//   SDRAM_AW    : SDRAM byte-address width
// -----------------------------------------------------------------------------
package laser500_pkg;

  localparam int SDRAM_AW = 25;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DL,
    OWN_VID,
    OWN_CPU
  } owner_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    COMPLETE
  } arb_state_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdram_arbiter_if
// Bundles every requester, response and SDRAM-controller signal of the
// arbiter. The slave modport is the arbiter's view; the master modport is the
// view of the surrounding requesters and SDRAM controller.
//   dl_*    : downloader write strobe, address, data, download-in-progress
//   vid_*   : video read strobe/address, ack pulse and read data
//   cpu_*   : CPU access strobe/we/address/wdata, ack, read data, wait_n stall
//   sdram_* : address/data/we/oe towards the controller, read data back
//   busy, overflow : status
// -----------------------------------------------------------------------------
interface sdram_arbiter_if
  import laser500_pkg::*;
#(
  parameter int AW = SDRAM_AW
);

  logic          dl_active;
  logic          dl_wr;
  logic [AW-1:0] dl_addr;
  logic [7:0]    dl_data;

  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [7:0]    vid_data;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;
  logic          cpu_wait_n;

  logic [AW-1:0] sdram_addr;
  logic [7:0]    sdram_din;
  logic          sdram_we;
  logic          sdram_oe;
  logic [7:0]    sdram_dout;

  logic          busy;
  logic          overflow;

  modport slave (
    input  dl_active, dl_wr, dl_addr, dl_data,
    input  vid_req, vid_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  sdram_dout,
    output vid_ack, vid_data,
    output cpu_ack, cpu_rdata, cpu_wait_n,
    output sdram_addr, sdram_din, sdram_we, sdram_oe,
    output busy, overflow
  );

  modport master (
    output dl_active, dl_wr, dl_addr, dl_data,
    output vid_req, vid_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output sdram_dout,
    input  vid_ack, vid_data,
    input  cpu_ack, cpu_rdata, cpu_wait_n,
    input  sdram_addr, sdram_din, sdram_we, sdram_oe,
    input  busy, overflow
  );

endinterface

// File: rtl/sdram_req_slot.sv
// -----------------------------------------------------------------------------
// sdram_req_slot
// One pending-request slot: a valid bit plus latched address, data and we.
//   clk, rst   : clock, asynchronous active-high reset
//   strobe_i   : 1-cycle request strobe; loads the slot when accepted
//   addr_i, data_i, we_i : request fields, sampled with strobe_i
//   grant_i    : arbiter picked this slot; clears the valid bit
//   busy_i     : this requester's access is currently in flight
//   valid_o, addr_o, data_o, we_o : slot contents
//   drop_o     : strobe rejected (slot full or access in flight)
// -----------------------------------------------------------------------------
module sdram_req_slot #(
  parameter int AW = 25
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          strobe_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    data_i,
  input  logic          we_i,
  input  logic          grant_i,
  input  logic          busy_i,
  output logic          valid_o,
  output logic [AW-1:0] addr_o,
  output logic [7:0]    data_o,
  output logic          we_o,
  output logic          drop_o
);

  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          we_q, we_d;

  // NOTE: every variable gets its default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    drop_o  = strobe_i && (valid_q || busy_i);

    // A grant needs valid_q and an accepted strobe needs !valid_q, so the two
    // updates below never collide.
    if (grant_i) begin
      valid_d = 1'b0;
    end
    if (strobe_i && !drop_o) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
      we_d    = we_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, matching the hardware.
  // NOTE: the field registers are plain flops, not a RAM, so resetting them is
  // cheap and keeps the outputs deterministic after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign we_o    = we_q;

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
// Shares one 8-bit SDRAM port between the ROM downloader, the video fetcher
// and the Z80 CPU. Requests are latched into pending slots and served as
// 2-cycle transactions (ACCESS, COMPLETE); read data returns with a 1-cycle
// ack; the CPU is stalled through cpu_wait_n.
//   F14M  : system clock
//   RESET : asynchronous active-high reset
//   bus   : sdram_arbiter_if slave modport (requesters, acks, SDRAM side,
//           busy and sticky overflow)
// Parameters: AW address width; VID_FIXED 1 = video beats CPU, 0 = the two
// alternate on collisions.
// -----------------------------------------------------------------------------
module sdram_arbiter
  import laser500_pkg::*;
#(
  parameter int AW        = SDRAM_AW,
  parameter bit VID_FIXED = 1'b1
) (
  input  logic           F14M,
  input  logic           RESET,
  sdram_arbiter_if.slave bus
);

  arb_state_t    state_q, state_d;
  owner_t        owner_q, owner_d;
  logic          last_vid_q, last_vid_d;   // 1 = video granted last, 0 = CPU
  logic [AW-1:0] sdram_addr_q, sdram_addr_d;
  logic [7:0]    sdram_din_q, sdram_din_d;
  logic          sdram_we_q, sdram_we_d;
  logic          sdram_oe_q, sdram_oe_d;
  logic          busy_q, busy_d;
  logic          vid_ack_q, vid_ack_d;
  logic [7:0]    vid_data_q, vid_data_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [7:0]    cpu_rdata_q, cpu_rdata_d;
  logic          cpu_wait_n_q, cpu_wait_n_d;
  logic          overflow_q, overflow_d;

  logic          dl_slot_valid, vid_slot_valid, cpu_slot_valid;
  logic [AW-1:0] dl_slot_addr, vid_slot_addr, cpu_slot_addr;
  logic [7:0]    dl_slot_data, vid_slot_data, cpu_slot_data;
  logic          dl_slot_we, vid_slot_we, cpu_slot_we;
  logic          dl_drop, vid_drop, cpu_drop;
  logic          grant_dl, grant_vid, grant_cpu;
  logic          dl_busy, vid_busy, cpu_busy;
  logic          vid_ok, cpu_ok;
  owner_t        win;

  assign dl_busy  = (state_q != IDLE) && (owner_q == OWN_DL);
  assign vid_busy = (state_q != IDLE) && (owner_q == OWN_VID);
  assign cpu_busy = (state_q != IDLE) && (owner_q == OWN_CPU);

  sdram_req_slot #(.AW(AW)) u_dl_slot (
    .clk      (F14M),
    .rst      (RESET),
    .strobe_i (bus.dl_wr),
    .addr_i   (bus.dl_addr),
    .data_i   (bus.dl_data),
    .we_i     (1'b1),
    .grant_i  (grant_dl),
    .busy_i   (dl_busy),
    .valid_o  (dl_slot_valid),
    .addr_o   (dl_slot_addr),
    .data_o   (dl_slot_data),
    .we_o     (dl_slot_we),
    .drop_o   (dl_drop)
  );

  sdram_req_slot #(.AW(AW)) u_vid_slot (
    .clk      (F14M),
    .rst      (RESET),
    .strobe_i (bus.vid_req),
    .addr_i   (bus.vid_addr),
    .data_i   (8'h00),
    .we_i     (1'b0),
    .grant_i  (grant_vid),
    .busy_i   (vid_busy),
    .valid_o  (vid_slot_valid),
    .addr_o   (vid_slot_addr),
    .data_o   (vid_slot_data),
    .we_o     (vid_slot_we),
    .drop_o   (vid_drop)
  );

  sdram_req_slot #(.AW(AW)) u_cpu_slot (
    .clk      (F14M),
    .rst      (RESET),
    .strobe_i (bus.cpu_req),
    .addr_i   (bus.cpu_addr),
    .data_i   (bus.cpu_wdata),
    .we_i     (bus.cpu_we),
    .grant_i  (grant_cpu),
    .busy_i   (cpu_busy),
    .valid_o  (cpu_slot_valid),
    .addr_o   (cpu_slot_addr),
    .data_o   (cpu_slot_data),
    .we_o     (cpu_slot_we),
    .drop_o   (cpu_drop)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_vid_d   = last_vid_q;
    sdram_addr_d = sdram_addr_q;
    sdram_din_d  = sdram_din_q;
    sdram_we_d   = 1'b0;
    sdram_oe_d   = 1'b0;
    busy_d       = 1'b0;
    vid_ack_d    = 1'b0;
    vid_data_d   = vid_data_q;
    cpu_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    grant_dl     = 1'b0;
    grant_vid    = 1'b0;
    grant_cpu    = 1'b0;
    overflow_d   = overflow_q | dl_drop | vid_drop | cpu_drop;
    cpu_wait_n_d = ~(cpu_slot_valid | cpu_busy | bus.dl_active);

    // Video and CPU stay pending (not dropped) while a download runs.
    vid_ok = vid_slot_valid && !bus.dl_active;
    cpu_ok = cpu_slot_valid && !bus.dl_active;

    win = OWN_NONE;
    if (dl_slot_valid) begin
      win = OWN_DL;
    end else if (vid_ok && cpu_ok) begin
      win = (VID_FIXED || !last_vid_q) ? OWN_VID : OWN_CPU;
    end else if (vid_ok) begin
      win = OWN_VID;
    end else if (cpu_ok) begin
      win = OWN_CPU;
    end

    // Read data is valid in COMPLETE; the ack is registered for the next cycle.
    if (state_q == COMPLETE) begin
      case (owner_q)
        OWN_VID: begin
          vid_ack_d  = 1'b1;
          vid_data_d = bus.sdram_dout;
        end
        OWN_CPU: begin
          cpu_ack_d = 1'b1;
          if (!sdram_we_q) begin
            cpu_rdata_d = bus.sdram_dout;
          end
        end
        default: ;
      endcase
    end

    if (state_q == ACCESS) begin
      state_d    = COMPLETE;
      sdram_we_d = sdram_we_q;
      sdram_oe_d = sdram_oe_q;
      busy_d     = 1'b1;
    end else begin
      // IDLE and COMPLETE both arbitrate, giving back-to-back 2-cycle accesses.
      case (win)
        OWN_DL: begin
          grant_dl     = 1'b1;
          sdram_addr_d = dl_slot_addr;
          sdram_din_d  = dl_slot_data;
          sdram_we_d   = dl_slot_we;
        end
        OWN_VID: begin
          grant_vid    = 1'b1;
          sdram_addr_d = vid_slot_addr;
          sdram_din_d  = vid_slot_data;
          sdram_we_d   = vid_slot_we;
          last_vid_d   = 1'b1;
        end
        OWN_CPU: begin
          grant_cpu    = 1'b1;
          sdram_addr_d = cpu_slot_addr;
          sdram_din_d  = cpu_slot_data;
          sdram_we_d   = cpu_slot_we;
          last_vid_d   = 1'b0;
        end
        default: ;
      endcase

      if (win != OWN_NONE) begin
        state_d    = ACCESS;
        owner_d    = win;
        sdram_oe_d = ~sdram_we_d;
        busy_d     = 1'b1;
      end else begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    end
  end

  always_ff @(posedge F14M or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      owner_q      <= OWN_NONE;
      last_vid_q   <= 1'b0;
      sdram_addr_q <= '0;
      sdram_din_q  <= '0;
      sdram_we_q   <= 1'b0;
      sdram_oe_q   <= 1'b0;
      busy_q       <= 1'b0;
      vid_ack_q    <= 1'b0;
      vid_data_q   <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_wait_n_q <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_vid_q   <= last_vid_d;
      sdram_addr_q <= sdram_addr_d;
      sdram_din_q  <= sdram_din_d;
      sdram_we_q   <= sdram_we_d;
      sdram_oe_q   <= sdram_oe_d;
      busy_q       <= busy_d;
      vid_ack_q    <= vid_ack_d;
      vid_data_q   <= vid_data_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_wait_n_q <= cpu_wait_n_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.sdram_addr = sdram_addr_q;
  assign bus.sdram_din  = sdram_din_q;
  assign bus.sdram_we   = sdram_we_q;
  assign bus.sdram_oe   = sdram_oe_q;
  assign bus.busy       = busy_q;
  assign bus.vid_ack    = vid_ack_q;
  assign bus.vid_data   = vid_data_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.cpu_wait_n = cpu_wait_n_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single 8-bit SDRAM port between three requesters: the ROM/PRG downloader, the video fetcher and the Z80 CPU path. It sits between those requesters and the `sdram` controller and replaces the combinational download mux at top level. It latches requests into pending slots, grants one 2-cycle SDRAM transaction at a time, returns read data with an ack pulse, and drives the CPU `WAIT_n` stall.

## Interface
- `AW`, default 25: SDRAM byte-address width.
- `VID_FIXED`, default 1: 1 = video has fixed priority over the CPU; 0 = video and CPU round-robin.

Ports:
- `F14M` in, 1: system clock.
- `RESET` in, 1: asynchronous, active-high reset.
- `dl_active` in, 1: download in progress (the downloader's `downloading` output).
- `dl_wr` in, 1: 1-cycle download write strobe.
- `dl_addr` in, AW: download write address, sampled on `dl_wr`.
- `dl_data` in, 8: download write data, sampled on `dl_wr`.
- `vid_req` in, 1: 1-cycle video read strobe.
- `vid_addr` in, AW: video read address, sampled on `vid_req`.
- `vid_ack` out, 1: 1-cycle pulse; `vid_data` is valid while it is high.
- `vid_data` out, 8: video read data.
- `cpu_req` in, 1: 1-cycle CPU access strobe.
- `cpu_we` in, 1: 1 = write, 0 = read; sampled on `cpu_req`.
- `cpu_addr` in, AW: CPU address, sampled on `cpu_req`.
- `cpu_wdata` in, 8: CPU write data, sampled on `cpu_req`.
- `cpu_ack` out, 1: 1-cycle completion pulse.
- `cpu_rdata` out, 8: CPU read data, valid while `cpu_ack` is high.
- `cpu_wait_n` out, 1: 0 while a CPU access is pending or in flight, or while `dl_active` is high.
- `sdram_addr` out, AW: address to the SDRAM controller.
- `sdram_din` out, 8: write data to the SDRAM controller.
- `sdram_we` out, 1: write enable to the SDRAM controller.
- `sdram_oe` out, 1: read enable to the SDRAM controller.
- `sdram_dout` in, 8: read data from the SDRAM controller, valid in the COMPLETE cycle.
- `busy` out, 1: 1 in ACCESS and COMPLETE.
- `overflow` out, 1: sticky error flag; cleared only by `RESET`.

## Operation
- Each requester has a pending slot: a valid bit plus latched address, data and we.
- A strobe sets the slot's valid bit and loads the slot fields.
- A strobe arriving while that requester's slot is already valid, or its access is in flight, is dropped and sets `overflow`.
- FSM states:
  - IDLE: no transaction.
  - ACCESS: SDRAM signals driven, cycle 1.
  - COMPLETE: signals still driven; `sdram_dout` is captured.
- Arbitration runs in IDLE and in COMPLETE. If any eligible slot is valid, the winner's slot is cleared, its fields are registered onto the `sdram_*` outputs, and the next state is ACCESS. Otherwise the next state is IDLE.
- Priority:
  - The download slot always wins.
  - While `dl_active` = 1, the video and CPU slots are ineligible; they stay pending and are not dropped.
  - Between video and CPU: with `VID_FIXED` = 1, video wins. With `VID_FIXED` = 0, the requester not granted last wins; a 1-bit `last_owner` is updated on each video/CPU grant.
- Download and CPU writes drive `sdram_we` = 1, `sdram_oe` = 0. Reads drive `sdram_we` = 0, `sdram_oe` = 1. In IDLE, `sdram_we` = `sdram_oe` = 0 and `sdram_addr`/`sdram_din` hold their last values.
- In COMPLETE, the owner's ack is registered for the next cycle:
  - Video read: `vid_data` <= `sdram_dout`.
  - CPU read: `cpu_rdata` <= `sdram_dout`.
  - CPU write: `cpu_ack` pulses; `cpu_rdata` is unchanged.
  - Download: no ack.
- `cpu_wait_n` = ~(cpu slot valid | CPU in flight | `dl_active`). It is registered and updates the cycle after the cause changes.

## Timing
- Reset values:
  - State IDLE; all slots invalid.
  - `sdram_we`, `sdram_oe`, `vid_ack`, `cpu_ack`, `busy`, `overflow` = 0.
  - `sdram_addr`, `sdram_din`, `vid_data`, `cpu_rdata` = 0.
  - `cpu_wait_n` = 1; `last_owner` = CPU.
- Idle read latency: strobe at cycle n.
  - n+1: slot valid, arbitrated.
  - n+2: ACCESS.
  - n+3: COMPLETE.
  - n+4: ack high with data.
- Back-to-back throughput is one access per 2 cycles.
- A strobe in the same cycle as that requester's ack is legal and is not an overflow.
- An asynchronous `RESET` during ACCESS or COMPLETE aborts immediately: `sdram_we`/`sdram_oe` drop, no ack is produced, and all pending slots are lost.
- `dl_active` rising while a video/CPU access is in flight: the transaction completes and is acked normally; arbitration masking applies from the next arbitration point.

## Structure
- `laser500_pkg` holds:
  - The `owner_t` enum: OWN_NONE, OWN_DL, OWN_VID, OWN_CPU.
  - The `arb_state_t` enum: IDLE, ACCESS, COMPLETE.
  - The `SDRAM_AW` = 25 constant.
- Sub-module `sdram_req_slot` (parameter AW) is instantiated three times. It contains the valid bit, address/data/we registers, the set-on-strobe / clear-on-grant logic and overflow detection.

## Test plan
- Single video read: `vid_req` at cycle 10 with addr 0x1234, model returns 0xA5 -> `sdram_oe` high in cycles 12–13, `vid_ack` = 1 with `vid_data` = 0xA5 at cycle 14.
- Simultaneous video and CPU read, `VID_FIXED` = 0 -> exactly one access per 2 cycles, grants alternate on repeated collisions, and both ack in order.
- CPU write 0x3C to 0x8000 -> `cpu_wait_n` goes 0; `sdram_we` = 1 for 2 cycles with `sdram_din` = 0x3C; `cpu_ack` pulses; `cpu_wait_n` returns to 1.
- Video and CPU requests pending with `dl_active` = 1 and `dl_wr` bursts every 8 cycles -> only download writes are issued; when `dl_active` falls, both pending requests are served.
- Second `vid_req` issued before the first is acked -> `overflow` = 1 and stays 1; exactly one `vid_ack` is produced.
- `RESET` pulsed during ACCESS -> `sdram_oe` = 0 asynchronously, no ack, all outputs at reset values.
